simple_alu_streamer: RTL and testbench
======================================

# simple_alu_streamer

Initiator-side traffic engine for the simple ALU accelerator. It generates the A and B operand streams as arithmetic sequences and drives them over per-port valid-ready handshakes. It then accepts the result stream, counting results and optionally accumulating a checksum. It sits between the CSR/control layer and the ALU datapath, so a single `start_i` pulse runs an entire job of `num_ops_i` operations.

## Interface
Parameters:
- `DataWidth`, 64, width of operands and results.
- `CntWidth`, 16, width of operation counters and `num_ops_i`.
- `MaxOutstanding`, 2, maximum issued-but-unreturned operations (≥1).

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  job start pulse; sampled only in IDLE.
- `num_ops_i`  in  CntWidth  operations in job.
- `a_init_i`, `a_step_i`  in  DataWidth  first A operand, A increment.
- `b_init_i`, `b_step_i`  in  DataWidth  first B operand, B increment.
- `a_o`  out  DataWidth  A operand.
- `a_valid_o`  out  1  A valid.
- `a_ready_i`  in  1  A ready.
- `b_o`  out  DataWidth  B operand.
- `b_valid_o`  out  1  B valid.
- `b_ready_i`  in  1  B ready.
- `result_i`  in  DataWidth  result data.
- `result_valid_i`  in  1  result valid.
- `result_ready_o`  out  1  result ready.
- `busy_o`  out  1  job in progress.
- `done_o`  out  1  one-cycle job-complete pulse.
- `result_cnt_o`  out  CntWidth  results received in current/last job.
- `checksum_o`  out  DataWidth  sum of results of current/last job.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start_i`, with `num_ops_i` > 0.
  - IDLE → DONE on `start_i`, with `num_ops_i` == 0.
  - RUN → DONE when `result_cnt` == latched `num_ops` (including the cycle the last result fires).
  - DONE → IDLE unconditionally.
- On accepted start:
  - Latch `num_ops`, the init values and the step values.
  - Clear `a_cnt`, `b_cnt`, `result_cnt` and `checksum`.
  - Load `a_o` = `a_init_i` and `b_o` = `b_init_i`.
- `start_i` is ignored in RUN and DONE.
- Each port is independent. For port X:
  - `X_valid_o` = RUN && `X_cnt` < `num_ops` && (`X_cnt` − `result_cnt`) < `MaxOutstanding`.
  - A transfer occurs on `X_valid_o && X_ready_i`.
  - On a transfer: `X_cnt` += 1 and `X_o` += `X_step`, with wrap modulo 2^DataWidth.
  - `X_o` is stable while valid is high and no transfer has occurred.
- Valid outputs never depend combinationally on ready inputs.
- `result_ready_o` = RUN && `result_cnt` < `num_ops`.
  - A result transfer increments `result_cnt` and adds `result_i` to `checksum`, modulo 2^DataWidth.
  - Results presented outside RUN are not accepted.
- `busy_o` = (state != IDLE).
- `done_o` = (state == DONE).
- `result_cnt_o` and `checksum_o` hold their values after DONE until the next accepted start.
- A transfer on A, a transfer on B and a result transfer in the same cycle are all legal, and all counters update together.
- Reset in any state: return to IDLE and clear all counters. All outputs go to 0, with `a_o` = `b_o` = 0.

## Timing
- Start accepted at edge t: `busy_o` = 1 and the first operands are valid in cycle t+1.
- Issue rate: with ready held high, one operand per port per cycle, limited by `MaxOutstanding`.
- Job end: the last result accepted at edge t puts `done_o` high in cycle t+1 and `busy_o` low in cycle t+2.
- `num_ops` == 0: `done_o` is high in cycle t+1 and no valids are ever asserted.
- Back-to-back jobs: a new start is accepted in the first IDLE cycle after DONE.

## Configuration
- Macro `SIMPLE_ALU_STREAMER_CHECKSUM_EN`.
  - Defined: the checksum accumulator is present as described above.
  - Undefined: no accumulator register and `checksum_o` is tied to 0. All other behaviour is identical.

## Structure
- Shared package `simple_alu_pkg` holds:
  - The `streamer_state_e` enum (IDLE, RUN, DONE).
  - Default width constants.
- One sub-module, `simple_alu_opgen`, instantiated once each for A and B. It contains:
  - The operand register and step adder.
  - The per-port count and valid logic.
  - Inputs: `load`, `init`, `step`, `enable`, `ready`, `credit_ok`. Outputs: `data`, `valid`, `cnt`.

## Test plan
- Basic job: start with `num_ops`=4, A=(1,+1), B=(10,+2), all ready high, ALU model adding the operands.
  - Required: A = 1,2,3,4; B = 10,12,14,16.
  - Required: `result_cnt_o` = 4, `checksum_o` = 62, one `done_o` pulse.
- Backpressure: random toggling of `a_ready_i`/`b_ready_i`.
  - Required: operands stable while stalled, no sequence element lost or duplicated, valids never dropped without a transfer.
- Outstanding limit: `MaxOutstanding`=2, result stream stalled.
  - Required: exactly 2 operands issued per port, then valids low until a result returns.
- Wrap: with `DataWidth`=8, `a_init`=0xFE and `a_step`=1.
  - Required: A sequence = 0xFE, 0xFF, 0x00.
- Zero length and restart:
  - `num_ops`=0 gives `done_o` in cycle t+1 with no valids.
  - `start_i` during RUN is ignored.
  - `rst_i` asserted mid-job returns to IDLE with all outputs 0.
- Macro off: the same run as the basic job gives `checksum_o`=0 and `result_cnt_o`=4.

Source files
------------

// File: rtl/simple_alu_pkg.sv
// Shared types and default widths for the simple ALU accelerator blocks.
package simple_alu_pkg;

    localparam int DEFAULT_DATA_WIDTH      = 64;
    localparam int DEFAULT_CNT_WIDTH       = 16;
    localparam int DEFAULT_MAX_OUTSTANDING = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } streamer_state_e;

endpackage

// File: rtl/simple_alu_opgen.sv
// One operand stream: arithmetic-sequence register, step adder, issue count and valid.
module simple_alu_opgen
    import simple_alu_pkg::*;
#(
    parameter int DataWidth = DEFAULT_DATA_WIDTH,
    parameter int CntWidth  = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DataWidth-1:0] init,
    input  logic [DataWidth-1:0] step,
    input  logic                 enable,
    input  logic                 ready,
    input  logic                 credit_ok,
    output logic [DataWidth-1:0] data,
    output logic                 valid,
    output logic [CntWidth-1:0]  cnt
);

    logic [DataWidth-1:0] step_q;
    logic                 fire;

    // valid is built only from registered state, so it never follows ready.
    assign valid = enable && credit_ok;
    assign fire  = valid && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            data   <= '0;
            step_q <= '0;
            cnt    <= '0;
        end else if (load) begin
            data   <= init;
            step_q <= step;
            cnt    <= '0;
        end else if (fire) begin
            data <= data + step_q;
            cnt  <= cnt + CntWidth'(1);
        end
    end

endmodule

// File: rtl/simple_alu_streamer.sv
// Job engine: issues A/B operand sequences and collects results for one start pulse.
// Optional checksum accumulator enabled by `define SIMPLE_ALU_STREAMER_CHECKSUM_EN.
module simple_alu_streamer
    import simple_alu_pkg::*;
#(
    parameter int DataWidth      = DEFAULT_DATA_WIDTH,
    parameter int CntWidth       = DEFAULT_CNT_WIDTH,
    parameter int MaxOutstanding = DEFAULT_MAX_OUTSTANDING
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [CntWidth-1:0]  num_ops_i,
    input  logic [DataWidth-1:0] a_init_i,
    input  logic [DataWidth-1:0] a_step_i,
    input  logic [DataWidth-1:0] b_init_i,
    input  logic [DataWidth-1:0] b_step_i,
    output logic [DataWidth-1:0] a_o,
    output logic                 a_valid_o,
    input  logic                 a_ready_i,
    output logic [DataWidth-1:0] b_o,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    input  logic [DataWidth-1:0] result_i,
    input  logic                 result_valid_i,
    output logic                 result_ready_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CntWidth-1:0]  result_cnt_o,
    output logic [DataWidth-1:0] checksum_o,
    output streamer_state_e      state_o
);

    streamer_state_e     state_q, state_d;
    logic [CntWidth-1:0] num_ops_q;
    logic [CntWidth-1:0] result_cnt_q;
    logic [CntWidth-1:0] a_cnt, b_cnt;
    logic                run, start_ok, result_fire;
    logic                a_enable, b_enable, a_credit, b_credit;

    assign run      = (state_q == RUN);
    assign start_ok = (state_q == IDLE) && start_i;

    // Handshakes: a beat moves on a rising edge where valid && ready; valid is
    // registered-state only and, once high, holds with stable data until that beat.
    assign a_enable = run && (a_cnt < num_ops_q);
    assign b_enable = run && (b_cnt < num_ops_q);
    assign a_credit = (a_cnt - result_cnt_q) < CntWidth'(MaxOutstanding);
    assign b_credit = (b_cnt - result_cnt_q) < CntWidth'(MaxOutstanding);

    assign result_ready_o = run && (result_cnt_q < num_ops_q);
    assign result_fire    = result_valid_i && result_ready_o;

    simple_alu_opgen #(
        .DataWidth (DataWidth),
        .CntWidth  (CntWidth)
    ) u_opgen_a (
        .clk       (clk_i),
        .rst       (rst_i),
        .load      (start_ok),
        .init      (a_init_i),
        .step      (a_step_i),
        .enable    (a_enable),
        .ready     (a_ready_i),
        .credit_ok (a_credit),
        .data      (a_o),
        .valid     (a_valid_o),
        .cnt       (a_cnt)
    );

    simple_alu_opgen #(
        .DataWidth (DataWidth),
        .CntWidth  (CntWidth)
    ) u_opgen_b (
        .clk       (clk_i),
        .rst       (rst_i),
        .load      (start_ok),
        .init      (b_init_i),
        .step      (b_step_i),
        .enable    (b_enable),
        .ready     (b_ready_i),
        .credit_ok (b_credit),
        .data      (b_o),
        .valid     (b_valid_o),
        .cnt       (b_cnt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (num_ops_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Leave on the same edge that accepts the final result.
                if ((result_cnt_q == num_ops_q) ||
                    (result_fire && ((result_cnt_q + CntWidth'(1)) == num_ops_q))) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            num_ops_q    <= '0;
            result_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                num_ops_q    <= num_ops_i;
                result_cnt_q <= '0;
            end else if (result_fire) begin
                result_cnt_q <= result_cnt_q + CntWidth'(1);
            end
        end
    end

`ifdef SIMPLE_ALU_STREAMER_CHECKSUM_EN
    logic [DataWidth-1:0] checksum_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            checksum_q <= '0;
        end else if (start_ok) begin
            checksum_q <= '0;
        end else if (result_fire) begin
            checksum_q <= checksum_q + result_i;
        end
    end

    assign checksum_o = checksum_q;
`else
    logic unused_result;
    assign unused_result = ^result_i;
    assign checksum_o    = '0;
`endif

    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign result_cnt_o = result_cnt_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_simple_alu_streamer.sv
// Directed bench for simple_alu_streamer with an adder ALU model and expected-queue scoreboard.
module tb_simple_alu_streamer;
    import simple_alu_pkg::*;

    localparam int DW = 8;
    localparam int CW = 16;
    localparam int MO = 2;
`ifdef SIMPLE_ALU_STREAMER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic            clk;
    logic            rst_i;
    logic            start_i;
    logic [CW-1:0]   num_ops_i;
    logic [DW-1:0]   a_init_i, a_step_i, b_init_i, b_step_i;
    logic [DW-1:0]   a_o, b_o;
    logic            a_valid_o, a_ready_i, b_valid_o, b_ready_i;
    logic [DW-1:0]   result_i;
    logic            result_valid_i, result_ready_o;
    logic            busy_o, done_o;
    logic [CW-1:0]   result_cnt_o;
    logic [DW-1:0]   checksum_o;
    streamer_state_e state_o;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] exp_a_q[$];
    logic [DW-1:0] exp_b_q[$];
    logic [DW-1:0] a_pend[$];
    logic [DW-1:0] b_pend[$];
    logic [DW-1:0] res_q[$];

    bit rdy_rand      = 1'b0;
    bit res_en        = 1'b1;
    bit exp_done_next = 1'b0;
    int a_issued      = 0;
    int b_issued      = 0;
    int res_acc       = 0;
    int job_n         = 0;

    simple_alu_streamer #(
        .DataWidth      (DW),
        .CntWidth       (CW),
        .MaxOutstanding (MO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .num_ops_i      (num_ops_i),
        .a_init_i       (a_init_i),
        .a_step_i       (a_step_i),
        .b_init_i       (b_init_i),
        .b_step_i       (b_step_i),
        .a_o            (a_o),
        .a_valid_o      (a_valid_o),
        .a_ready_i      (a_ready_i),
        .b_o            (b_o),
        .b_valid_o      (b_valid_o),
        .b_ready_i      (b_ready_i),
        .result_i       (result_i),
        .result_valid_i (result_valid_i),
        .result_ready_o (result_ready_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .result_cnt_o   (result_cnt_o),
        .checksum_o     (checksum_o),
        .state_o        (state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flush();
        exp_a_q.delete();
        exp_b_q.delete();
        a_pend.delete();
        b_pend.delete();
        res_q.delete();
        res_acc       = 0;
        job_n         = 0;
        exp_done_next = 1'b0;
    endtask

    // ALU model and monitor: drives ready/result at negedge, samples 1ns later
    // the beats that the next rising edge will take.
    initial begin : monitor
        bit            a_stall, b_stall;
        logic [DW-1:0] a_hold, b_hold;
        a_stall        = 1'b0;
        b_stall        = 1'b0;
        a_hold         = '0;
        b_hold         = '0;
        a_ready_i      = 1'b0;
        b_ready_i      = 1'b0;
        result_valid_i = 1'b0;
        result_i       = '0;
        forever begin
            @(negedge clk);
            a_ready_i      = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            b_ready_i      = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            result_valid_i = res_en && (res_q.size() > 0);
            result_i       = (res_q.size() > 0) ? res_q[0] : '0;
            #1;
            if (rst_i) begin
                a_stall       = 1'b0;
                b_stall       = 1'b0;
                exp_done_next = 1'b0;
                continue;
            end
            if (exp_done_next) begin
                check("done_after_last_result", done_o, 1);
                exp_done_next = 1'b0;
            end
            if (a_stall) begin
                check("a_stall_valid", a_valid_o, 1);
                check("a_stall_data", a_o, a_hold);
            end
            if (b_stall) begin
                check("b_stall_valid", b_valid_o, 1);
                check("b_stall_data", b_o, b_hold);
            end
            if (a_valid_o && a_ready_i) begin
                if (exp_a_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL a_extra: got a beat 0x%0h, expected no beat", a_o);
                end else begin
                    check("a_seq", a_o, exp_a_q.pop_front());
                end
                a_pend.push_back(a_o);
                a_issued++;
            end
            if (b_valid_o && b_ready_i) begin
                if (exp_b_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL b_extra: got a beat 0x%0h, expected no beat", b_o);
                end else begin
                    check("b_seq", b_o, exp_b_q.pop_front());
                end
                b_pend.push_back(b_o);
                b_issued++;
            end
            a_stall = a_valid_o && !a_ready_i;
            b_stall = b_valid_o && !b_ready_i;
            a_hold  = a_o;
            b_hold  = b_o;
            if (result_valid_i && result_ready_o) begin
                void'(res_q.pop_front());
                res_acc++;
                if (res_acc == job_n) exp_done_next = 1'b1;
            end
            while (a_pend.size() > 0 && b_pend.size() > 0) begin
                res_q.push_back(a_pend.pop_front() + b_pend.pop_front());
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        flush();
        @(negedge clk);
        #2;
        check("rst_a_o", a_o, 0);
        check("rst_b_o", b_o, 0);
        check("rst_a_valid", a_valid_o, 0);
        check("rst_b_valid", b_valid_o, 0);
        check("rst_result_ready", result_ready_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_result_cnt", result_cnt_o, 0);
        check("rst_checksum", checksum_o, 0);
        @(negedge clk);
        rst_i = 1'b0;
        flush();
    endtask

    task automatic start_job(input logic [CW-1:0] n, input logic [DW-1:0] ai, input logic [DW-1:0] as,
                             input logic [DW-1:0] bi, input logic [DW-1:0] bs);
        @(negedge clk);
        num_ops_i = n;
        a_init_i  = ai;
        a_step_i  = as;
        b_init_i  = bi;
        b_step_i  = bs;
        start_i   = 1'b1;
        a_issued  = 0;
        b_issued  = 0;
        res_acc   = 0;
        job_n     = int'(n);
        #2;
        check("idle_before_start", busy_o, 0);
        @(negedge clk);
        start_i   = 1'b0;
        num_ops_i = '0;
        a_init_i  = 8'h55;
        b_init_i  = 8'haa;
        #2;
        check("busy_after_start", busy_o, 1);
        if (n == '0) begin
            check("zero_done_t1", done_o, 1);
            check("zero_a_valid", a_valid_o, 0);
            check("zero_b_valid", b_valid_o, 0);
        end else begin
            check("a_valid_t1", a_valid_o, 1);
            check("b_valid_t1", b_valid_o, 1);
        end
    endtask

    task automatic wait_done(input string name, input logic [CW-1:0] n, input logic [DW-1:0] csum);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            #2;
            cyc++;
        end while (!done_o && cyc < 300);
        if (!done_o) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no done_o, expected done_o within 300 cycles", name);
            return;
        end
        check({name, "_result_cnt"}, result_cnt_o, n);
        check({name, "_checksum"}, checksum_o, CSUM_EN ? csum : 8'h00);
        check({name, "_a_left"}, exp_a_q.size(), 0);
        check({name, "_b_left"}, exp_b_q.size(), 0);
    endtask

    task automatic post_idle(input string name, input logic [CW-1:0] n);
        @(negedge clk);
        #2;
        check({name, "_done_one_cycle"}, done_o, 0);
        check({name, "_busy_low"}, busy_o, 0);
        check({name, "_cnt_hold"}, result_cnt_o, n);
        check({name, "_no_result_ready"}, result_ready_o, 0);
    endtask

    initial begin
        rst_i     = 1'b1;
        start_i   = 1'b0;
        num_ops_i = '0;
        a_init_i  = '0;
        a_step_i  = '0;
        b_init_i  = '0;
        b_step_i  = '0;
        do_reset();

        // basic job; the wrap job starts in the first IDLE cycle after DONE
        exp_a_q = '{8'd1, 8'd2, 8'd3, 8'd4};
        exp_b_q = '{8'd10, 8'd12, 8'd14, 8'd16};
        start_job(16'd4, 8'd1, 8'd1, 8'd10, 8'd2);
        wait_done("basic", 16'd4, 8'd62);

        exp_a_q = '{8'hfe, 8'hff, 8'h00};
        exp_b_q = '{8'h01, 8'h02, 8'h03};
        start_job(16'd3, 8'hfe, 8'h01, 8'h01, 8'h01);
        wait_done("wrap", 16'd3, 8'h03);
        post_idle("wrap", 16'd3);

        // backpressure on both operand ports
        rdy_rand = 1'b1;
        exp_a_q = '{8'd3, 8'd8, 8'd13, 8'd18, 8'd23};
        exp_b_q = '{8'd100, 8'd110, 8'd120, 8'd130, 8'd140};
        start_job(16'd5, 8'd3, 8'd5, 8'd100, 8'd10);
        wait_done("bp", 16'd5, 8'd153);
        rdy_rand = 1'b0;
        post_idle("bp", 16'd5);

        // outstanding limit with the result stream stalled
        res_en  = 1'b0;
        exp_a_q = '{8'd5, 8'd8, 8'd11, 8'd14};
        exp_b_q = '{8'd7, 8'd8, 8'd9, 8'd10};
        start_job(16'd4, 8'd5, 8'd3, 8'd7, 8'd1);
        repeat (6) @(negedge clk);
        #2;
        check("outst_a_issued", a_issued, 2);
        check("outst_b_issued", b_issued, 2);
        check("outst_a_valid_low", a_valid_o, 0);
        check("outst_b_valid_low", b_valid_o, 0);
        res_en = 1'b1;
        wait_done("outst", 16'd4, 8'd72);
        post_idle("outst", 16'd4);

        // start during RUN is ignored
        exp_a_q = '{8'd20, 8'd21, 8'd22};
        exp_b_q = '{8'd0, 8'd4, 8'd8};
        start_job(16'd3, 8'd20, 8'd1, 8'd0, 8'd4);
        @(negedge clk);
        start_i   = 1'b1;
        num_ops_i = 16'd9;
        a_init_i  = 8'd99;
        b_init_i  = 8'd99;
        @(negedge clk);
        start_i = 1'b0;
        wait_done("ign", 16'd3, 8'd75);
        post_idle("ign", 16'd3);

        // zero-length job
        start_job(16'd0, 8'd1, 8'd1, 8'd1, 8'd1);
        @(negedge clk);
        #2;
        check("zero_busy_low", busy_o, 0);
        check("zero_result_cnt", result_cnt_o, 0);
        check("zero_checksum", checksum_o, 0);
        repeat (3) @(negedge clk);

        // reset in the middle of a job
        exp_a_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
        exp_b_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
        start_job(16'd6, 8'd1, 8'd1, 8'd1, 8'd1);
        repeat (3) @(negedge clk);
        do_reset();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
